uart_tx_word: RTL

Transmits a 32-bit word over a UART serial line as four 8N1 bytes, most significant byte first. It is the transmit-side counterpart of the word receiver used by the programmer/debug link, so host tools can read words back from the OTTER. It sits between core-side logic, which presents a word with a one-cycle start strobe, and the board's serial TX pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_word_if.sv | 12 +
 rtl/uart_tx.sv | 69 ++++++
 rtl/uart_tx_word.sv | 95 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word transmitter.
// Holds the frame length, the word-level FSM encoding and the bit-period helper.
package uart_pkg;

   localparam int FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE
   } state_e;

   // 64-bit intermediate so fast clocks cannot overflow the MHz-to-Hz product.
   function automatic int clks_per_bit(input int clk_rate_mhz, input int baud);
      longint num;
      num = longint'(clk_rate_mhz) * 64'sd1_000_000;
      return int'(num / longint'(baud));
   endfunction

endpackage

// File: rtl/uart_tx_word_if.sv
// Core-side handshake and serial pin of the UART word transmitter.
// The master is the core logic; the slave is uart_tx_word.
interface uart_tx_word_if;
   logic        start;
   logic [31:0] tx_word;
   logic        stx;
   logic        busy;
   logic        done;

   modport master (output start, tx_word, input stx, busy, done);
   modport slave  (input start, tx_word, output stx, busy, done);
endinterface

// File: rtl/uart_tx.sv
// 8N1 byte serializer. tx_done is high during the last cycle of the stop bit,
// and a tx_dv in that same cycle starts the next frame with no idle gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_dv,
   input  logic [7:0] tx_byte,
   output logic       tx_serial,
   output logic       tx_active,
   output logic       tx_done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [IDX_W-1:0] IDX_STOP  = IDX_W'(FRAME_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_DLAST = IDX_W'(FRAME_BITS - 2);

   logic [CNT_W-1:0] cnt_q;
   logic [IDX_W-1:0] idx_q;
   logic [7:0]       shift_q;
   logic             serial_q;
   logic             active_q;
   logic             done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         serial_q <= 1'b1;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // Raised one cycle early so it coincides with the final stop-bit cycle.
         done_q <= active_q && (idx_q == IDX_STOP) && (cnt_q == CNT_PRE);
         if (tx_dv && (!active_q || done_q)) begin
            shift_q  <= tx_byte;
            serial_q <= 1'b0;
            active_q <= 1'b1;
            cnt_q    <= '0;
            idx_q    <= '0;
         end else if (active_q) begin
            if (cnt_q == CNT_LAST) begin
               cnt_q <= '0;
               if (idx_q == IDX_STOP) begin
                  active_q <= 1'b0;
                  serial_q <= 1'b1;
               end else begin
                  idx_q    <= idx_q + 1'b1;
                  serial_q <= (idx_q == IDX_DLAST) ? 1'b1 : shift_q[0];
                  shift_q  <= {1'b0, shift_q[7:1]};
               end
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign tx_serial = serial_q;
   assign tx_active = active_q;
   assign tx_done   = done_q;

endmodule

// File: rtl/uart_tx_word.sv
// Sends a 32-bit word as four back-to-back 8N1 bytes, most significant first,
// with a one-cycle done pulse after the last stop bit.
module uart_tx_word
   import uart_pkg::*;
#(
   parameter int CLK_RATE = -1,
   parameter int BAUD     = 115200
) (
   input logic           clk,
   input logic           rst,
   uart_tx_word_if.slave bus
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD);

   if (CLKS_PER_BIT < 2) begin : g_rate_check
      $error("uart_tx_word: CLKS_PER_BIT must be at least 2");
   end

   state_e      state_q;
   logic [1:0]  byte_idx_q;
   logic [31:0] word_q;
   logic        busy_q;
   logic        done_q;

   logic        tx_dv_d;
   logic [7:0]  tx_byte_d;
   logic [1:0]  nxt_idx_d;
   logic        accept_d;
   logic        next_byte_d;
   logic        tx_serial;
   logic        tx_active;
   logic        tx_done;

   // The first byte goes straight from tx_word so its start bit follows the accept edge.
   always_comb begin
      accept_d    = bus.start && ((state_q == IDLE) || (state_q == DONE));
      next_byte_d = (state_q == SEND) && tx_active && tx_done && (byte_idx_q != 2'd3);
      nxt_idx_d   = byte_idx_q + 2'd1;
      tx_dv_d     = accept_d || next_byte_d;
      tx_byte_d   = accept_d ? bus.tx_word[31:24] : word_q[{~nxt_idx_d, 3'b000} +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         byte_idx_q <= 2'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (bus.start) begin
                  word_q     <= bus.tx_word;
                  byte_idx_q <= 2'd0;
                  busy_q     <= 1'b1;
                  state_q    <= SEND;
               end else begin
                  state_q <= IDLE;
               end
            end
            SEND: begin
               if (tx_active && tx_done) begin
                  if (byte_idx_q == 2'd3) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     byte_idx_q <= nxt_idx_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk      (clk),
      .rst      (rst),
      .tx_dv    (tx_dv_d),
      .tx_byte  (tx_byte_d),
      .tx_serial(tx_serial),
      .tx_active(tx_active),
      .tx_done  (tx_done)
   );

   assign bus.stx  = tx_serial;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
